// File: rtl/mem_responder.sv
// Memory-side read/write responder: reads return mem_rdy WAIT_CYCLES+1 cycles after valid is
// sampled; posted writes never stall. Optional access checking via `define MEM_ERR_CHK_EN.
module mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              valid,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              mem_rdy,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] addr_idx;
  logic [31:0]      rdata_q;
  logic [31:0]      rd_val;
  logic             addr_bad;
  logic             rd_err;
  logic             wr_en;
  logic             rd_start;

  logic [31:0]      mem [DEPTH_WORDS];

  assign addr_idx = addr[IDX_W+1:2];
  assign wr_en    = mem_we & ~addr_bad;
  assign rd_start = (state_q == IDLE) & valid;

  // Store has no reset: contents survive sys_rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_idx] <= wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-first: a same-cycle write to the latched word is forwarded into the response.
  always_comb begin
    rd_val = mem[idx_q];
    if (wr_en && (addr_idx == idx_q)) begin
      rd_val = wdata;
    end
    if (rd_err) begin
      rd_val = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_start) begin
        idx_q <= addr_idx;
      end
      if (state_q == RESP) begin
        rdata_q <= rd_val;
      end
    end
  end

  assign mem_rdy = (state_q == RESP);
  assign busy    = (state_q != IDLE);
  assign rdata   = mem_rdy ? rd_val : rdata_q;

`ifdef MEM_ERR_CHK_EN
  logic rd_err_q;
  logic wr_err_q;

  assign addr_bad = (addr[1:0] != 2'b00) || (addr[ADDR_W-1:IDX_W+2] != '0);

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= mem_we & addr_bad;
      if (rd_start) begin
        rd_err_q <= addr_bad;
      end
    end
  end

  assign rd_err = rd_err_q;
  assign err    = wr_err_q | (mem_rdy & rd_err_q);
`else
  logic unused_addr;

  // Without checking, out-of-range and misaligned addresses simply alias.
  assign unused_addr = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0]};
  assign addr_bad    = 1'b0;
  assign rd_err      = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized + directed bench for mem_responder against a cycle-arithmetic reference model.
module tb_mem_responder;

  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int IDX_W = 10;
  localparam int WC    = 2;

  logic          clk;
  logic          sys_rst;
  logic          valid;
  logic          mem_we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          mem_rdy;
  logic [31:0]   rdata;
  logic          busy;
  logic          err;

  mem_responder #(.ADDR_W(AW), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .valid   (valid),
    .mem_we  (mem_we),
    .addr    (addr),
    .wdata   (wdata),
    .mem_rdy (mem_rdy),
    .rdata   (rdata),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: a read accepted in cycle a responds in cycle a+WC+1, is busy for
  // cycles a+1..a+WC+2, and the responder is free again from cycle a+WC+3.
  int          cyc      = 0;
  bit          model_on = 0;
  bit          pend     = 0;
  int          rsp_c    = 0;
  int          free_c   = 0;
  logic [IDX_W-1:0] p_idx = '0;
  bit          p_err    = 0;
  logic [31:0] hold     = '0;
  bit          wr_err   = 0;
  logic [31:0] mm [DEPTH];

  function automatic bit bad(input logic [31:0] a);
`ifdef MEM_ERR_CHK_EN
    return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [IDX_W-1:0] widx(input logic [31:0] a);
    return a[IDX_W+1:2];
  endfunction

  function automatic logic [31:0] resp_val();
    if (p_err) return 32'h0;
    if (mem_we && !bad(addr) && widx(addr) == p_idx) return wdata;
    return mm[p_idx];
  endfunction

  always @(posedge clk) begin
    if (sys_rst) begin
      model_on = 1;
      pend     = 0;
      hold     = '0;
      wr_err   = 0;
    end else if (model_on) begin
      bit accept;
      if (pend && cyc == rsp_c) hold = resp_val();
      accept = (!pend || cyc >= free_c) && valid;
      wr_err = mem_we && bad(addr);
      if (mem_we && !bad(addr)) mm[widx(addr)] = wdata;
      if (accept) begin
        pend   = 1;
        rsp_c  = cyc + WC + 1;
        free_c = cyc + WC + 3;
        p_idx  = widx(addr);
        p_err  = bad(addr);
      end
    end
    cyc = cyc + 1;
  end

  always begin
    @(negedge clk);
    #3;
    if (model_on) begin
      bit          e_rdy;
      bit          e_busy;
      logic [31:0] e_rdata;
      e_rdy   = pend && (cyc == rsp_c);
      e_busy  = pend && (cyc < free_c);
      e_rdata = e_rdy ? resp_val() : hold;
      chk("rdy",   {31'd0, mem_rdy}, {31'd0, e_rdy});
      chk("busy",  {31'd0, busy},    {31'd0, e_busy});
      chk("err",   {31'd0, err},     {31'd0, wr_err || (e_rdy && p_err)});
      chk("rdata", rdata, e_rdata);
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    valid  = 1'b0;
    mem_we = 1'b1;
    addr   = a;
    wdata  = d;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  // Issues one read, optionally moving addr during the wait and/or writing in the RESP cycle.
  // Leaves valid high through the DONE cycle, as the core's lagging valid would.
  task automatic do_read(input logic [31:0] a, input logic [31:0] alt, input bit coll,
                         input logic [31:0] cdat, input logic [31:0] exp_d,
                         input bit exp_e, input string nm);
    int n;
    bit seen;
    @(negedge clk);
    valid  = 1'b1;
    mem_we = 1'b0;
    addr   = a;
    n      = 0;
    seen   = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      addr   = alt;
      mem_we = 1'b0;
      if (coll && n == WC + 1) begin
        mem_we = 1'b1;
        addr   = a;
        wdata  = cdat;
      end
      #3;
      if (mem_rdy === 1'b1) seen = 1;
    end
    chk({nm, "_latency"}, n, WC + 1);
    chk({nm, "_rdata"}, rdata, exp_d);
    chk({nm, "_err"}, {31'd0, err}, {31'd0, exp_e});
    @(negedge clk);
    mem_we = 1'b0;
    addr   = alt;
    #3;
    chk({nm, "_done_rdy"}, {31'd0, mem_rdy}, 32'd0);
    chk({nm, "_done_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic go_idle(input string nm);
    @(negedge clk);
    valid  = 1'b0;
    mem_we = 1'b0;
    #3;
    chk({nm, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    sys_rst = 1'b1;
    valid   = 1'b0;
    mem_we  = 1'b0;
    addr    = '0;
    wdata   = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("reset_rdy",   {31'd0, mem_rdy}, 32'd0);
    chk("reset_busy",  {31'd0, busy},    32'd0);
    chk("reset_err",   {31'd0, err},     32'd0);
    chk("reset_rdata", rdata,            32'd0);
    @(negedge clk);
    sys_rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      mem_we = 1'b1;
      addr   = i * 4;
      wdata  = $urandom;
    end
    @(negedge clk);
    mem_we = 1'b0;

    // Write then read back; busy must be low right after DONE.
    wr(32'h10, 32'hDEADBEEF);
    do_read(32'h10, 32'h10, 0, 32'h0, 32'hDEADBEEF, 0, "t1");
    go_idle("t1");

    // Write in the RESP cycle to the pending word wins.
    do_read(32'h20, 32'h20, 1, 32'h12345678, 32'h12345678, 0, "t3");
    go_idle("t3");
    do_read(32'h20, 32'h20, 0, 32'h0, 32'h12345678, 0, "t3b");
    go_idle("t3b");

    // Reset during WAIT drops the read.
    @(negedge clk);
    valid = 1'b1;
    addr  = 32'h10;
    @(negedge clk);
    valid   = 1'b0;
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    #3;
    chk("t4_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      chk("t4_no_rdy", {31'd0, mem_rdy}, 32'd0);
    end
    do_read(32'h10, 32'h10, 0, 32'h0, 32'hDEADBEEF, 0, "t4");
    go_idle("t4");

    // Back-to-back fetches with addr wandering during the wait.
    wr(32'h0, 32'h11110000);
    wr(32'h4, 32'h22220004);
    wr(32'h8, 32'h33330008);
    do_read(32'h0, 32'h40, 0, 32'h0, 32'h11110000, 0, "t6a");
    do_read(32'h4, 32'h8,  0, 32'h0, 32'h22220004, 0, "t6b");
    do_read(32'h8, 32'h0,  0, 32'h0, 32'h33330008, 0, "t6c");
    go_idle("t6");

    // Misaligned access: errors with checking, aliases onto 0x10 without.
`ifdef MEM_ERR_CHK_EN
    do_read(32'h13, 32'h13, 0, 32'h0, 32'h0, 1, "t5r");
    go_idle("t5r");
    wr(32'h13, 32'h0BADF00D);
    #3;
    chk("t5_wr_err", {31'd0, err}, 32'd1);
    do_read(32'h10, 32'h10, 0, 32'h0, 32'hDEADBEEF, 0, "t5");
`else
    do_read(32'h13, 32'h13, 0, 32'h0, 32'hDEADBEEF, 0, "t5r");
    go_idle("t5r");
    wr(32'h13, 32'h0BADF00D);
    #3;
    chk("t5_wr_err", {31'd0, err}, 32'd0);
    do_read(32'h10, 32'h10, 0, 32'h0, 32'h0BADF00D, 0, "t5");
`endif
    go_idle("t5");

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      a = ($urandom % 8) << 2;
      if ($urandom % 8 == 0) a = a | ($urandom & 32'hFFFF_F000);
      if ($urandom % 8 == 0) a = a | ($urandom % 4);
      addr    = a;
      wdata   = $urandom;
      valid   = ($urandom % 2) == 0;
      mem_we  = ($urandom % 4) == 0;
      sys_rst = ($urandom % 64) == 0;
      if (sys_rst) mem_we = 1'b0;
    end
    @(negedge clk);
    sys_rst = 1'b0;
    valid   = 1'b0;
    mem_we  = 1'b0;
    repeat (10) @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
